// File: rtl/wb_serial_master.sv
// ---------------------------------------------------------------------------
// wb_serial_master
//
// Wishbone bus master driven by a byte stream (typically a UART rx/tx byte
// interface). A host sends either a write command
//     0x57 'W', 4 address bytes (MSB first), 4 data bytes (MSB first)
// or a read command
//     0x52 'R', 4 address bytes (MSB first)
// and the block runs one 32-bit Wishbone cycle. The result goes back as bytes:
//     write ok   -> 0x4B 'K'
//     read ok    -> 4 read data bytes, MSB first
//     err/timeout-> 0x45 'E'
// Any other byte seen while idle is silently discarded.
//
// Parameters:
//     timeout   cycles wb_cyc_o may stay high without ack/err before the
//               access is abandoned and reported as an error (2..65535)
//
// Ports:
//     clk, reset            system clock, synchronous active-high reset
//     rx_data, rx_avail     incoming byte and its one-cycle valid strobe
//     tx_data, tx_wr        outgoing byte and its one-cycle write strobe
//     tx_busy               transmitter busy, no tx_wr is issued while high
//     wb_adr_o, wb_dat_o    Wishbone address and write data
//     wb_dat_i              Wishbone read data
//     wb_sel_o, wb_we_o     byte selects (always 4'hF) and write enable
//     wb_cyc_o, wb_stb_o    Wishbone cycle and strobe
//     wb_ack_i, wb_err_i    Wishbone acknowledge and error
//     busy                  high whenever a command is being handled
// ---------------------------------------------------------------------------
module wb_serial_master #(
    parameter int timeout = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam logic [7:0]  CMD_WRITE = 8'h57;
    localparam logic [7:0]  CMD_READ  = 8'h52;
    localparam logic [7:0]  RSP_OK    = 8'h4B;
    localparam logic [7:0]  RSP_ERR   = 8'h45;

    // Terminal count of the bus watchdog: the counter starts at 0 on the
    // edge that raises wb_cyc_o, so reaching timeout-1 means wb_cyc_o has
    // been high for exactly 'timeout' cycles when the access is dropped.
    localparam logic [15:0] TMO_LAST  = 16'(timeout - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP,
        TXWAIT
    } state_t;

    state_t      state;
    logic [2:0]  byte_cnt;
    logic        is_write;
    logic [31:0] resp_data;
    logic [15:0] tmo_cnt;

    // The whole controller lives in one clocked process so every output is a
    // register. byte_cnt counts received bytes while collecting a command and
    // is reused as the number of response bytes still to send in RESP.
    // The response is held left-aligned in resp_data and shifted out from the
    // top byte, so a single-byte reply and a four-byte read reply share the
    // same transmit path.
    //
    // Transmit pacing: a byte is launched from RESP when tx_busy is low. The
    // following edge (still in RESP, tx_wr high) ends the pulse and either
    // finishes the command or moves to TXWAIT, which burns one more cycle so
    // tx_busy is never sampled before the transmitter has had a chance to
    // raise it. That gives a minimum of three cycles between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= 3'd0;
            is_write  <= 1'b0;
            resp_data <= 32'h0;
            tmo_cnt   <= 16'h0;
            tx_data   <= 8'h00;
            tx_wr     <= 1'b0;
            wb_adr_o  <= 32'h0;
            wb_dat_o  <= 32'h0;
            wb_sel_o  <= 4'hF;
            wb_we_o   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wb_sel_o <= 4'hF;
            case (state)
                IDLE: begin
                    tx_wr <= 1'b0;
                    if (rx_avail && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                        is_write <= (rx_data == CMD_WRITE);
                        byte_cnt <= 3'd0;
                        busy     <= 1'b1;
                        state    <= ADDR;
                    end
                end

                ADDR: begin
                    if (rx_avail) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        if (byte_cnt == 3'd3) begin
                            byte_cnt <= 3'd0;
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                wb_we_o  <= 1'b0;
                                tmo_cnt  <= 16'h0;
                                state    <= BUS;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end

                DATA: begin
                    if (rx_avail) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        if (byte_cnt == 3'd3) begin
                            byte_cnt <= 3'd0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            tmo_cnt  <= 16'h0;
                            state    <= BUS;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end

                // Priority here is err, then ack, then watchdog expiry: an
                // ack on the terminal-count cycle still counts as success,
                // while err always turns the result into an error reply.
                BUS: begin
                    if (wb_err_i || (!wb_ack_i && tmo_cnt == TMO_LAST)) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        resp_data <= {RSP_ERR, 24'h0};
                        byte_cnt  <= 3'd1;
                        state     <= RESP;
                    end else if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        resp_data <= is_write ? {RSP_OK, 24'h0} : wb_dat_i;
                        byte_cnt  <= is_write ? 3'd1 : 3'd4;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                RESP: begin
                    if (tx_wr) begin
                        tx_wr     <= 1'b0;
                        resp_data <= {resp_data[23:0], 8'h00};
                        byte_cnt  <= byte_cnt - 3'd1;
                        if (byte_cnt == 3'd1) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= TXWAIT;
                        end
                    end else if (!tx_busy) begin
                        tx_data <= resp_data[31:24];
                        tx_wr   <= 1'b1;
                    end
                end

                TXWAIT: begin
                    tx_wr <= 1'b0;
                    state <= RESP;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_serial_master.sv
// ---------------------------------------------------------------------------
// tb_wb_serial_master
//
// Directed bench for wb_serial_master (timeout = 16). A behavioural
// Wishbone slave answers with ack, err or nothing after a programmable
// number of cycles, and a transmitter model can hold tx_busy high for a
// number of cycles after each tx_wr. Transmitted bytes are logged and
// compared against hand-computed replies.
// ---------------------------------------------------------------------------
module tb_wb_serial_master;

    localparam int MODE_ACK  = 0;
    localparam int MODE_ERR  = 1;
    localparam int MODE_NONE = 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_avail  = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy   = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i  = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i  = 1'b0;
    logic        wb_err_i  = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          slv_mode  = MODE_ACK;
    int          slv_delay = 1;
    logic [31:0] slv_rdata = 32'h0;
    int          bp_len    = 0;

    logic [7:0] tx_log [0:63];
    int tx_n         = 0;
    int cyc_n        = 0;
    int last_pulse   = -100;
    int busy_left    = 0;
    int tx_viol      = 0;
    int spacing_viol = 0;
    int tx_cyc_viol  = 0;
    int stable_viol  = 0;

    int          cyc_high_cnt = 0;
    int          bus_count    = 0;
    int          wait_cnt     = 0;
    logic        prev_cyc     = 1'b0;
    logic [31:0] seen_adr     = 32'h0;
    logic [31:0] seen_dat     = 32'h0;
    logic        seen_we      = 1'b0;

    wb_serial_master #(.timeout(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .busy     (busy)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between transmit strobes.
    always @(posedge clk) cyc_n++;

    // Transmitter model: logs every byte, flags strobes issued while busy,
    // during a bus cycle or closer than three cycles apart, and holds
    // tx_busy high for bp_len cycles after each strobe.
    always @(negedge clk) begin
        if (tx_wr) begin
            if (tx_n < 64) tx_log[tx_n] = tx_data;
            tx_n++;
            if (tx_busy) tx_viol++;
            if (wb_cyc_o) tx_cyc_viol++;
            if (cyc_n - last_pulse < 3) spacing_viol++;
            last_pulse = cyc_n;
        end
        if (tx_wr && bp_len > 0) busy_left = bp_len;
        else if (busy_left > 0) busy_left--;
        tx_busy = (busy_left > 0);
    end

    // Wishbone slave model: counts how long wb_cyc_o stays high, checks the
    // request stays stable, and after slv_delay cycles answers for exactly one
    // cycle with ack (plus read data) or err, or never answers at all.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        if (wb_cyc_o) begin
            if (!prev_cyc) begin
                bus_count++;
                cyc_high_cnt = 0;
                wait_cnt     = 0;
                seen_adr     = wb_adr_o;
                seen_dat     = wb_dat_o;
                seen_we      = wb_we_o;
            end else if (wb_adr_o !== seen_adr || wb_dat_o !== seen_dat ||
                         wb_we_o !== seen_we || wb_stb_o !== 1'b1) begin
                stable_viol++;
            end
            cyc_high_cnt++;
            if (slv_mode != MODE_NONE && wait_cnt == slv_delay) begin
                if (slv_mode == MODE_ACK) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = slv_rdata;
                end else begin
                    wb_err_i = 1'b1;
                end
            end
            wait_cnt++;
        end
        prev_cyc = wb_cyc_o;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one byte on rx_data with a one-cycle rx_avail strobe and
    // returns on the falling edge right after the DUT has sampled it.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_avail = 1'b1;
        @(negedge clk);
        rx_avail = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic sendWord(input logic [31:0] w);
        applyStimulus(w[31:24]);
        applyStimulus(w[23:16]);
        applyStimulus(w[15:8]);
        applyStimulus(w[7:0]);
    endtask

    task automatic sendWrite(input logic [31:0] adr, input logic [31:0] dat);
        applyStimulus(8'h57);
        sendWord(adr);
        sendWord(dat);
    endtask

    task automatic sendRead(input logic [31:0] adr);
        applyStimulus(8'h52);
        sendWord(adr);
    endtask

    // Waits (bounded) for n transmit strobes, then checks busy is still high
    // on the last strobe and low one cycle later.
    task automatic finishResponse(input string tag, input int n, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            @(negedge clk);
            if (tx_wr) got++;
        end
        checkOutput({tag, " tx count"}, 32'(got), 32'(n));
        checkOutput({tag, " busy on last tx"}, 32'(busy), 32'h1);
        @(negedge clk);
        checkOutput({tag, " busy after last tx"}, 32'(busy), 32'h0);
    endtask

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int start;
        int bc;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset tx_wr",    32'(tx_wr),    32'h0);
        checkOutput("reset tx_data",  32'(tx_data),  32'h0);
        checkOutput("reset wb_adr_o", wb_adr_o,      32'h0);
        checkOutput("reset wb_dat_o", wb_dat_o,      32'h0);
        checkOutput("reset wb_sel_o", 32'(wb_sel_o), 32'hF);
        checkOutput("reset wb_we_o",  32'(wb_we_o),  32'h0);
        checkOutput("reset wb_cyc_o", 32'(wb_cyc_o), 32'h0);
        checkOutput("reset wb_stb_o", 32'(wb_stb_o), 32'h0);
        checkOutput("reset busy",     32'(busy),     32'h0);
        repeat (2) @(negedge clk);

        $display("[TB] write, ack after 3 cycles");
        slv_mode  = MODE_ACK;
        slv_delay = 3;
        start     = tx_n;
        bc        = bus_count;
        sendWrite(32'h0000_0010, 32'hDEAD_BEEF);
        checkOutput("wr cyc start", 32'(wb_cyc_o), 32'h1);
        checkOutput("wr stb start", 32'(wb_stb_o), 32'h1);
        checkOutput("wr we",        32'(wb_we_o),  32'h1);
        checkOutput("wr sel",       32'(wb_sel_o), 32'hF);
        checkOutput("wr adr",       wb_adr_o,      32'h0000_0010);
        checkOutput("wr dat",       wb_dat_o,      32'hDEAD_BEEF);
        checkOutput("wr busy",      32'(busy),     32'h1);
        finishResponse("wr", 1, 200);
        checkOutput("wr reply",     32'(tx_log[start]), 32'h4B);
        checkOutput("wr bus count", 32'(bus_count - bc), 32'h1);
        checkOutput("wr cyc cycles", 32'(cyc_high_cnt), 32'd4);
        repeat (5) @(negedge clk);

        $display("[TB] read with backpressure");
        slv_delay = 1;
        slv_rdata = 32'h1234_5678;
        bp_len    = 20;
        start     = tx_n;
        sendRead(32'h4000_0004);
        checkOutput("rd cyc start", 32'(wb_cyc_o), 32'h1);
        checkOutput("rd we",        32'(wb_we_o),  32'h0);
        checkOutput("rd adr",       wb_adr_o,      32'h4000_0004);
        finishResponse("rd", 4, 600);
        checkOutput("rd byte0", 32'(tx_log[start]),     32'h12);
        checkOutput("rd byte1", 32'(tx_log[start + 1]), 32'h34);
        checkOutput("rd byte2", 32'(tx_log[start + 2]), 32'h56);
        checkOutput("rd byte3", 32'(tx_log[start + 3]), 32'h78);
        checkOutput("rd cyc cycles", 32'(cyc_high_cnt), 32'd2);
        bp_len = 0;
        repeat (5) @(negedge clk);

        $display("[TB] garbage then read");
        applyStimulus(8'h00);
        checkOutput("garbage 00 busy", 32'(busy), 32'h0);
        applyStimulus(8'hFF);
        checkOutput("garbage FF busy", 32'(busy), 32'h0);
        applyStimulus(8'h41);
        checkOutput("garbage 41 busy", 32'(busy), 32'h0);
        slv_delay = 2;
        slv_rdata = 32'hCAFE_F00D;
        start     = tx_n;
        sendRead(32'h0000_0100);
        checkOutput("gr adr", wb_adr_o, 32'h0000_0100);
        finishResponse("gr", 4, 400);
        checkOutput("gr byte0", 32'(tx_log[start]),     32'hCA);
        checkOutput("gr byte1", 32'(tx_log[start + 1]), 32'hFE);
        checkOutput("gr byte2", 32'(tx_log[start + 2]), 32'hF0);
        checkOutput("gr byte3", 32'(tx_log[start + 3]), 32'h0D);
        checkOutput("gr cyc cycles", 32'(cyc_high_cnt), 32'd3);
        repeat (5) @(negedge clk);

        $display("[TB] read timeout");
        slv_mode = MODE_NONE;
        start    = tx_n;
        sendRead(32'h0000_0020);
        finishResponse("to", 1, 200);
        checkOutput("to reply",      32'(tx_log[start]), 32'h45);
        checkOutput("to cyc cycles", 32'(cyc_high_cnt),  32'd16);
        checkOutput("to cyc low",    32'(wb_cyc_o),      32'h0);
        repeat (5) @(negedge clk);

        $display("[TB] write with bus error");
        slv_mode  = MODE_ERR;
        slv_delay = 1;
        start     = tx_n;
        sendWrite(32'h0000_0030, 32'h1122_3344);
        checkOutput("er we", 32'(wb_we_o), 32'h1);
        finishResponse("er", 1, 200);
        repeat (30) @(negedge clk);
        checkOutput("er reply count", 32'(tx_n - start), 32'h1);
        checkOutput("er reply",       32'(tx_log[start]), 32'h45);

        $display("[TB] reset during bus access");
        slv_mode = MODE_NONE;
        start    = tx_n;
        sendWrite(32'h0000_0060, 32'h55AA_55AA);
        checkOutput("rst cyc before", 32'(wb_cyc_o), 32'h1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst cyc",  32'(wb_cyc_o), 32'h0);
        checkOutput("rst stb",  32'(wb_stb_o), 32'h0);
        checkOutput("rst we",   32'(wb_we_o),  32'h0);
        checkOutput("rst busy", 32'(busy),     32'h0);
        checkOutput("rst adr",  wb_adr_o,      32'h0);
        repeat (40) @(negedge clk);
        checkOutput("rst no reply", 32'(tx_n - start), 32'h0);
        slv_mode  = MODE_ACK;
        slv_delay = 1;
        start     = tx_n;
        sendWrite(32'h0000_0070, 32'h0BAD_F00D);
        checkOutput("post adr", wb_adr_o, 32'h0000_0070);
        checkOutput("post dat", wb_dat_o, 32'h0BAD_F00D);
        checkOutput("post we",  32'(wb_we_o), 32'h1);
        finishResponse("post", 1, 200);
        checkOutput("post reply", 32'(tx_log[start]), 32'h4B);
        repeat (5) @(negedge clk);

        checkOutput("tx while tx_busy",   32'(tx_viol),      32'h0);
        checkOutput("tx spacing",         32'(spacing_viol), 32'h0);
        checkOutput("tx during bus",      32'(tx_cyc_viol),  32'h0);
        checkOutput("bus request stable", 32'(stable_viol),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
